// File: rtl/sequence_controller.sv
// -----------------------------------------------------------------------------
// sequence_controller
//
// Run controller for the sequence step counter. A software start arms a run
// that follows the free-running step counter. Every step advances a LUT
// address that wraps at a programmable period length (num_steps). Completed
// periods are counted, and the run terminates after num_periods periods.
// num_periods == 0 means the run never ends on its own. All outputs are
// registered.
//
// Ports:
//   i_clk            system clock
//   i_aresetn        synchronous active-low reset
//   i_start          single-cycle request to begin a run
//   i_abort          single-cycle request to stop a run immediately
//   i_step_counter   step count from the stepper (rises by at most 1 per clk)
//   i_num_steps      steps per period, latched at accepted start (0 invalid)
//   i_num_periods    periods per run, latched at accepted start (0 = infinite)
//   o_lut_addr       current step index within the period
//   o_step_valid     one-cycle pulse: o_lut_addr is a new active step
//   o_period_count   completed periods in the current run
//   o_running        high in RUNNING
//   o_done           high in DONE
//   o_overrun        sticky: step counter jumped by more than 1 in RUNNING
//   o_cfg_err        sticky: start rejected because num_steps == 0
//
// State     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no run active, waiting for an accepted start
// S_RUNNING | run active, each step event advances the LUT address
// S_DONE    | requested number of periods completed, outputs holding
// -----------------------------------------------------------------------------
module sequence_controller #(
  parameter int STEP_W = 64,
  parameter int ADDR_W = 14,
  parameter int REP_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_aresetn,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [STEP_W-1:0] i_step_counter,
  input  logic [ADDR_W-1:0] i_num_steps,
  input  logic [REP_W-1:0]  i_num_periods,
  output logic [ADDR_W-1:0] o_lut_addr,
  output logic              o_step_valid,
  output logic [REP_W-1:0]  o_period_count,
  output logic              o_running,
  output logic              o_done,
  output logic              o_overrun,
  output logic              o_cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  logic [STEP_W-1:0] r_last_step;
  logic [ADDR_W-1:0] r_num_steps;
  logic [REP_W-1:0]  r_num_periods;
  logic [ADDR_W-1:0] r_lut_addr;
  logic              r_step_valid;
  logic [REP_W-1:0]  r_period_count;
  logic              r_running;
  logic              r_done;
  logic              r_overrun;
  logic              r_cfg_err;

  logic [STEP_W-1:0] w_step_diff;
  logic              w_step_event;
  logic              w_step_jump;
  logic              w_cfg_ok;
  logic              w_last_in_period;
  logic [REP_W-1:0]  w_period_inc;
  logic              w_run_complete;

  // Modulo subtraction makes the counter wrapping to 0 look like a +1 step.
  assign w_step_diff      = i_step_counter - r_last_step;
  assign w_step_event     = (w_step_diff != '0);
  assign w_step_jump      = (w_step_diff > STEP_W'(1));
  assign w_cfg_ok         = (i_num_steps != '0);
  assign w_last_in_period = (r_lut_addr == (r_num_steps - ADDR_W'(1)));
  assign w_period_inc     = r_period_count + REP_W'(1);
  assign w_run_complete   = (r_num_periods != '0) && (w_period_inc == r_num_periods);

  // The step history is tracked in every state, including reset, so that
  // leaving reset or IDLE never produces a spurious step event.
  always_ff @(posedge i_clk) begin
    r_last_step <= i_step_counter;
  end

  always_ff @(posedge i_clk) begin
    if (!i_aresetn) begin
      r_state        <= S_IDLE;
      r_num_steps    <= '0;
      r_num_periods  <= '0;
      r_lut_addr     <= '0;
      r_step_valid   <= 1'b0;
      r_period_count <= '0;
      r_running      <= 1'b0;
      r_done         <= 1'b0;
      r_overrun      <= 1'b0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_step_valid <= 1'b0;
      if (i_abort) begin
        // Abort wins over start; period_count keeps the partial result.
        r_state    <= S_IDLE;
        r_lut_addr <= '0;
        r_running  <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (i_start) begin
              if (w_cfg_ok) begin
                r_state        <= S_RUNNING;
                r_num_steps    <= i_num_steps;
                r_num_periods  <= i_num_periods;
                r_lut_addr     <= '0;
                r_period_count <= '0;
                r_step_valid   <= 1'b1;
                r_running      <= 1'b1;
                r_done         <= 1'b0;
                r_overrun      <= 1'b0;
                r_cfg_err      <= 1'b0;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end
          end

          S_RUNNING: begin
            if (w_step_event) begin
              if (w_step_jump) begin
                r_overrun <= 1'b1;
              end
              if (!w_last_in_period) begin
                r_lut_addr   <= r_lut_addr + ADDR_W'(1);
                r_step_valid <= 1'b1;
              end else begin
                r_lut_addr     <= '0;
                r_period_count <= w_period_inc;
                if (w_run_complete) begin
                  r_state   <= S_DONE;
                  r_running <= 1'b0;
                  r_done    <= 1'b1;
                end else begin
                  r_step_valid <= 1'b1;
                end
              end
            end
          end

          default: begin
            r_state    <= S_IDLE;
            r_lut_addr <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_lut_addr     = r_lut_addr;
  assign o_step_valid   = r_step_valid;
  assign o_period_count = r_period_count;
  assign o_running      = r_running;
  assign o_done         = r_done;
  assign o_overrun      = r_overrun;
  assign o_cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_sequence_controller.sv
// -----------------------------------------------------------------------------
// tb_sequence_controller
//
// Directed scenarios followed by randomized traffic. A run-level reference
// model tracks the number of step events since the accepted start and derives
// the LUT address and period count from it arithmetically; every cycle all
// outputs are compared against that model.
// -----------------------------------------------------------------------------
module tb_sequence_controller;

  localparam int STEP_W = 64;
  localparam int ADDR_W = 14;
  localparam int REP_W  = 32;

  logic              clk;
  logic              aresetn;
  logic              start;
  logic              abort;
  logic [STEP_W-1:0] step_counter;
  logic [ADDR_W-1:0] num_steps;
  logic [REP_W-1:0]  num_periods;
  logic [ADDR_W-1:0] lut_addr;
  logic              step_valid;
  logic [REP_W-1:0]  period_count;
  logic              running;
  logic              done;
  logic              overrun;
  logic              cfg_err;

  sequence_controller #(
    .STEP_W (STEP_W),
    .ADDR_W (ADDR_W),
    .REP_W  (REP_W)
  ) dut (
    .i_clk          (clk),
    .i_aresetn      (aresetn),
    .i_start        (start),
    .i_abort        (abort),
    .i_step_counter (step_counter),
    .i_num_steps    (num_steps),
    .i_num_periods  (num_periods),
    .o_lut_addr     (lut_addr),
    .o_step_valid   (step_valid),
    .o_period_count (period_count),
    .o_running      (running),
    .o_done         (done),
    .o_overrun      (overrun),
    .o_cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: run mode plus number of step events since start.
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  int          m_mode   = M_IDLE;
  logic [63:0] m_prev   = '0;
  logic [63:0] m_k      = '0;
  logic [63:0] m_n      = '0;
  logic [63:0] m_p      = '0;
  logic [63:0] m_lut    = '0;
  logic [31:0] m_period = '0;
  logic        m_valid  = 1'b0;
  logic        m_over   = 1'b0;
  logic        m_cfg    = 1'b0;

  task automatic model_update();
    logic [63:0] d;
    d       = step_counter - m_prev;
    m_prev  = step_counter;
    m_valid = 1'b0;
    if (!aresetn) begin
      m_mode = M_IDLE; m_lut = 0; m_period = 0; m_over = 0; m_cfg = 0; m_k = 0;
    end else if (abort) begin
      m_mode = M_IDLE; m_lut = 0;
    end else if (m_mode != M_RUN) begin
      if (start) begin
        if (num_steps != 0) begin
          m_n = 64'(num_steps); m_p = 64'(num_periods);
          m_k = 0; m_lut = 0; m_period = 0; m_valid = 1'b1;
          m_cfg = 1'b0; m_over = 1'b0; m_mode = M_RUN;
        end else begin
          m_cfg = 1'b1;
        end
      end
    end else if (d != 0) begin
      if (d > 1) m_over = 1'b1;
      m_k = m_k + 1;
      if (m_p != 0 && m_k == m_n * m_p) begin
        m_mode = M_DONE; m_lut = 0; m_period = 32'(m_p);
      end else begin
        m_lut = m_k % m_n; m_period = 32'(m_k / m_n); m_valid = 1'b1;
      end
    end
  endtask

  // One clock: apply inputs, advance model at the edge, compare #1 later.
  task automatic cyc(input bit rstn, input bit st, input bit ab, input logic [63:0] inc);
    aresetn      = rstn;
    start        = st;
    abort        = ab;
    step_counter = step_counter + inc;
    @(posedge clk);
    model_update();
    #1;
    check("lut_addr",     64'(lut_addr),     m_lut);
    check("step_valid",   64'(step_valid),   64'(m_valid));
    check("period_count", 64'(period_count), 64'(m_period));
    check("running",      64'(running),      64'(m_mode == M_RUN));
    check("done",         64'(done),         64'(m_mode == M_DONE));
    check("overrun",      64'(overrun),      64'(m_over));
    check("cfg_err",      64'(cfg_err),      64'(m_cfg));
    if (step_valid) n_pulses++;
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; abort = 1'b0;
    step_counter = '0; num_steps = '0; num_periods = '0;

    // Reset
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    check("reset_lut", 64'(lut_addr), 0);
    check("reset_running", 64'(running), 0);
    cyc(1, 0, 0, 0);

    // Basic run N=3 P=2
    num_steps = 3; num_periods = 2;
    n_pulses = 0;
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    check("basic_pulses", 64'(n_pulses), 6);
    check("basic_done", 64'(done), 1);
    check("basic_period", 64'(period_count), 2);
    check("basic_lut", 64'(lut_addr), 0);

    // Infinite run N=4 P=0 (start from DONE)
    num_steps = 4; num_periods = 0;
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 1);
    check("inf_period", 64'(period_count), 5);
    check("inf_running", 64'(running), 1);
    check("inf_lut", 64'(lut_addr), 0);
    cyc(1, 0, 1, 0);

    // Abort mid-run N=5 P=3
    num_steps = 5; num_periods = 3;
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 0);
    check("abort_running", 64'(running), 0);
    check("abort_period", 64'(period_count), 1);
    n_pulses = 0;
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
    check("abort_no_pulses", 64'(n_pulses), 0);

    // Start with num_steps == 0
    num_steps = 0;
    cyc(1, 1, 0, 0);
    check("cfg_err_set", 64'(cfg_err), 1);
    check("cfg_err_idle", 64'(running), 0);

    // Start and abort together from IDLE
    num_steps = 2; num_periods = 1;
    cyc(1, 1, 1, 0);
    check("start_abort_idle", 64'(running), 0);
    cyc(1, 0, 0, 1);

    // Start while RUNNING is ignored
    num_steps = 3; num_periods = 0;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    num_steps = 5;
    cyc(1, 1, 0, 0);
    check("restart_lut", 64'(lut_addr), 2);
    cyc(1, 0, 0, 1);
    check("restart_period", 64'(period_count), 1);
    cyc(1, 0, 1, 0);

    // Overrun: 10 -> 13 while running
    step_counter = 64'd10;
    cyc(1, 0, 0, 0);
    num_steps = 6; num_periods = 0;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 3);
    check("overrun_set", 64'(overrun), 1);
    check("overrun_lut", 64'(lut_addr), 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1);
    check("overrun_sticky", 64'(overrun), 1);
    cyc(1, 0, 1, 0);
    check("overrun_after_abort", 64'(overrun), 1);
    cyc(1, 1, 0, 0);
    check("overrun_cleared", 64'(overrun), 0);
    cyc(1, 0, 1, 0);

    // Counter wrap 2^64-1 -> 0
    step_counter = '1;
    cyc(1, 0, 0, 0);
    num_steps = 4; num_periods = 0;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    check("wrap_lut", 64'(lut_addr), 1);
    check("wrap_overrun", 64'(overrun), 0);
    cyc(1, 0, 0, 1);

    // Reset mid-run
    cyc(0, 0, 0, 1);
    check("midrst_running", 64'(running), 0);
    check("midrst_lut", 64'(lut_addr), 0);
    check("midrst_valid", 64'(step_valid), 0);
    cyc(1, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit st, ab, rs;
      logic [63:0] inc;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) begin
        num_steps   = ($urandom_range(0, 15) == 0) ? 14'd0 : 14'($urandom_range(1, 6));
        num_periods = 32'($urandom_range(0, 3));
      end
      rs  = (r != 0);
      st  = ($urandom_range(0, 99) < 8);
      ab  = ($urandom_range(0, 99) < 3);
      r   = $urandom_range(0, 99);
      inc = (r < 40) ? 64'd0 : (r < 95) ? 64'd1 : 64'($urandom_range(2, 5));
      cyc(rs, st, ab, inc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_controller.md
Name: sequence_controller

Overview:
Run controller for the sequence step counter. It arms on a software start and follows the free-running step counter. It maps each step onto a LUT address that wraps at a programmable period length, counts completed periods, and terminates after a programmable number of periods (or runs indefinitely). Its outputs drive the sequence LUT read port and the run-status bits in the PS-visible register block.

Parameters:
STEP_W, 64, width of the incoming step counter
ADDR_W, 14, width of LUT address / steps-per-period
REP_W, 32, width of period counter / period limit

Ports:
clk  in  1  system clock
aresetn  in  1  synchronous active-low reset
start  in  1  single-cycle request to begin a run
abort  in  1  single-cycle request to stop a run immediately
step_counter  in  STEP_W  step count from the stepper; rises by at most 1 per clk
num_steps  in  ADDR_W  steps per period; latched at accepted start; 0 is invalid
num_periods  in  REP_W  periods per run; latched at accepted start; 0 = infinite
lut_addr  out  ADDR_W  current step index within the period
step_valid  out  1  one-cycle pulse: lut_addr is a new active step
period_count  out  REP_W  completed periods in the current run
running  out  1  high in RUNNING
done  out  1  high in DONE
overrun  out  1  sticky: step_counter jumped by more than 1 between cycles
cfg_err  out  1  sticky: start rejected because num_steps == 0

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-low (aresetn sampled on posedge clk).
  - Reset values: state IDLE, lut_addr 0, step_valid 0, period_count 0, running 0, done 0, overrun 0, cfg_err 0.
  - Reset mid-run returns everything to reset values with no further pulses.
- All outputs are registered.
- States: IDLE, RUNNING, DONE.
- Step tracking:
  - Internal last_step register loads step_counter every cycle in every state.
  - A step event is step_counter != last_step while in RUNNING.
  - Step arithmetic is modulo 2^STEP_W, so wrap of the counter to 0 counts as one event.
  - If (step_counter - last_step) > 1 in RUNNING, set overrun and still treat it as one event.
- IDLE:
  - start with num_steps != 0: latch num_steps and num_periods, then go to RUNNING next cycle. In that same edge: lut_addr = 0, period_count = 0, step_valid = 1, cfg_err cleared. Step 0 is active immediately.
  - start with num_steps == 0: stay in IDLE and set cfg_err.
- RUNNING, on a step event:
  - If lut_addr < N-1: lut_addr + 1 and pulse step_valid.
  - If lut_addr == N-1: period_count + 1.
    - If num_periods != 0 and period_count + 1 == num_periods: go to DONE, lut_addr = 0, no step_valid pulse.
    - Otherwise: lut_addr = 0 and pulse step_valid.
  - Latency from step_counter change to step_valid / lut_addr update is 1 clk.
  - start in RUNNING is ignored.
- DONE:
  - lut_addr and period_count hold; done = 1.
  - start behaves as in IDLE and begins a new run directly.
- abort in any state: next cycle state IDLE, lut_addr 0, step_valid 0, running 0, done 0. period_count holds its value.
- start and abort in the same cycle: abort wins and start is dropped.
- num_periods == 0: period_count wraps modulo 2^REP_W and the run never enters DONE.
- N == 1: every step event completes a period; lut_addr stays 0.
- overrun and cfg_err clear only on reset or on an accepted start.

Test Plan:
- Basic run: N=3, P=2, start, then 7 single increments of step_counter. Required: step_valid pulses with lut_addr sequence 0,1,2,0,1,2 (6 pulses). On the 6th increment: DONE, done=1, period_count=2, lut_addr=0, no further pulses.
- Infinite run: N=4, P=0, 20 step increments. Required: lut_addr cycles 0..3, period_count=5, running stays 1, done never asserted.
- Abort mid-run: N=5, P=3, abort after 7 steps. Required: next cycle IDLE, running=0, lut_addr=0, period_count=1; subsequent step_counter changes produce no step_valid.
- Start edge cases:
  - start with num_steps=0: cfg_err=1, state stays IDLE.
  - start and abort in the same cycle from IDLE: no run starts.
  - start while RUNNING: no effect on lut_addr or period_count.
- Overrun: step_counter jumps 10 -> 13 in RUNNING. Required: overrun=1, lut_addr advances by exactly 1, overrun persists until the next accepted start.
- Counter wrap: step_counter at 2^64-1, then 0 in RUNNING. Required: exactly one step event and no overrun. Also assert aresetn low mid-run: all outputs at reset values one cycle later.
